// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add 32x32 multiplier that borrows the core ALU's adder while busy.
// Optional early termination on an exhausted multiplier: define MULSEQ_EARLY_TERM_EN.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [WIDTH-1:0] i_dp_a,
    input  logic [WIDTH-1:0] i_dp_b,
    input  logic [1:0]       i_dp_control,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product,
    output logic [1:0]       o_mul_flags
);

    // state  | meaning
    // S_IDLE | ALU owned by the datapath, waiting for start
    // S_ITER | one multiplier bit consumed per cycle through the ALU adder
    // S_DONE | single-cycle done pulse; product latched on exit
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_product;
    logic [1:0]         r_flags;
    logic               w_last;
    logic               w_early;

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

`ifdef MULSEQ_EARLY_TERM_EN
    // Once every remaining multiplier bit is zero the accumulator is final.
    assign w_early = (r_mplr == '0);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_alu_a       = i_dp_a;
        o_alu_b       = i_dp_b;
        o_alu_control = i_dp_control;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                o_alu_a       = r_acc;
                o_alu_b       = r_mcand;
                o_alu_control = 2'b00;
                o_busy        = 1'b1;
                if (w_early || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_alu_a       = r_acc;
                o_alu_b       = r_mcand;
                o_alu_control = 2'b00;
                o_busy        = 1'b1;
                o_done        = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_flags   <= 2'b01;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_op_a;
                        r_mplr  <= i_op_b;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_ITER: begin
                    if (!w_early) begin
                        if (r_mplr[0]) begin
                            r_acc <= i_alu_result;
                        end
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_product <= r_acc;
                    r_flags   <= {r_acc[WIDTH-1], (r_acc == '0)};
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign o_product   = r_product;
    assign o_mul_flags = r_flags;

endmodule
